// File: rtl/ext_stage_if.sv
// ext_stage_if: request/response bundle between a pipeline stage and ext_stage.
// Signal names carry the i_/o_ direction as seen from ext_stage (the slave).
interface ext_stage_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 8
);
  localparam int AW = $clog2(DATA_W / 8);

  logic              i_in_valid;
  logic              i_stall;
  logic              i_flush;
  logic [2:0]        i_op;
  logic [IMM_W-1:0]  i_imm;
  logic [DATA_W-1:0] i_mem_data;
  logic [AW-1:0]     i_addr_lo;
  logic              o_out_valid;
  logic [DATA_W-1:0] o_ext_out;
  logic              o_out_err;
  logic [CNT_W-1:0]  o_err_cnt;

  modport master (
    output i_in_valid, i_stall, i_flush, i_op, i_imm, i_mem_data, i_addr_lo,
    input  o_out_valid, o_ext_out, o_out_err, o_err_cnt
  );

  modport slave (
    input  i_in_valid, i_stall, i_flush, i_op, i_imm, i_mem_data, i_addr_lo,
    output o_out_valid, o_ext_out, o_out_err, o_err_cnt
  );
endinterface

// File: rtl/ext_stage.sv
// ext_stage: registered immediate / load-data extension with misalignment
// detection and a saturating misalignment counter. One cycle of latency,
// priority per edge is reset > flush > stall > load.
module ext_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 8
) (
  input logic        i_clk,
  input logic        i_reset,
  ext_stage_if.slave bus
);
  localparam int AW = $clog2(DATA_W / 8);
  // Masks that round the byte offset down to a halfword / word boundary.
  localparam logic [AW-1:0]    HALF_MASK = ~AW'(1'b1);
  localparam logic [AW-1:0]    WORD_MASK = ~AW'(2'b11);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_SIGN = 3'd1,
    OP_LUI  = 3'd2,
    OP_LB   = 3'd3,
    OP_LBU  = 3'd4,
    OP_LH   = 3'd5,
    OP_LHU  = 3'd6,
    OP_LW   = 3'd7
  } op_e;

  logic [AW-1:0]           w_addr;
  logic [AW+2:0]           w_sh_b;
  logic [AW+2:0]           w_sh_h;
  logic [AW+2:0]           w_sh_w;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [31:0]             w_word;
  logic signed [IMM_W+15:0] w_lui_s;
  logic [DATA_W-1:0]       w_raw;
  logic [DATA_W-1:0]       w_result;
  logic                    w_misal;
  logic                    w_cnt_en;

  logic                    r_valid;
  logic                    r_err;
  logic [DATA_W-1:0]       r_ext;
  logic [CNT_W-1:0]        r_cnt;

  // Bit offsets of the selected byte, halfword and word inside mem_data.
  // A misaligned access still selects the enclosing lane; its value is
  // discarded below, so the rounding only keeps the selects in range.
  assign w_addr  = bus.i_addr_lo;
  assign w_sh_b  = {w_addr, 3'b000};
  assign w_sh_h  = {w_addr & HALF_MASK, 3'b000};
  assign w_sh_w  = {w_addr & WORD_MASK, 3'b000};
  assign w_byte  = bus.i_mem_data[w_sh_b +: 8];
  assign w_half  = bus.i_mem_data[w_sh_h +: 16];
  assign w_word  = bus.i_mem_data[w_sh_w +: 32];
  // Signed so that widening to DATA_W replicates imm's top bit.
  assign w_lui_s = {bus.i_imm, 16'h0000};

  // Decode the mode into the raw extended value and the misalignment flag.
  always_comb begin
    w_raw   = {DATA_W{1'b0}};
    w_misal = 1'b0;
    case (op_e'(bus.i_op))
      OP_ZERO: w_raw = DATA_W'(bus.i_imm);
      OP_SIGN: w_raw = DATA_W'($signed(bus.i_imm));
      OP_LUI:  w_raw = DATA_W'(w_lui_s);
      OP_LB:   w_raw = DATA_W'($signed(w_byte));
      OP_LBU:  w_raw = DATA_W'(w_byte);
      OP_LH: begin
        w_raw   = DATA_W'($signed(w_half));
        w_misal = w_addr[0];
      end
      OP_LHU: begin
        w_raw   = DATA_W'(w_half);
        w_misal = w_addr[0];
      end
      OP_LW: begin
        w_raw   = DATA_W'($signed(w_word));
        w_misal = |w_addr[1:0];
      end
      default: begin
        w_raw   = {DATA_W{1'b0}};
        w_misal = 1'b0;
      end
    endcase
  end

  // A misaligned access never exposes partial data.
  assign w_result = w_misal ? {DATA_W{1'b0}} : w_raw;
  // Count only accepted misaligned requests, stopping at the ceiling.
  assign w_cnt_en = bus.i_in_valid & w_misal & (r_cnt != CNT_MAX);

  // Output register and error counter, updated by reset > flush > stall > load.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ext   <= {DATA_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ext   <= {DATA_W{1'b0}};
      r_cnt   <= r_cnt;
    end else if (bus.i_stall) begin
      r_valid <= r_valid;
      r_err   <= r_err;
      r_ext   <= r_ext;
      r_cnt   <= r_cnt;
    end else begin
      r_valid <= bus.i_in_valid;
      if (bus.i_in_valid) begin
        r_ext <= w_result;
        r_err <= w_misal;
      end else begin
        r_ext <= {DATA_W{1'b0}};
        r_err <= 1'b0;
      end
      if (w_cnt_en) begin
        r_cnt <= r_cnt + CNT_W'(1'b1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign bus.o_out_valid = r_valid;
  assign bus.o_ext_out   = r_ext;
  assign bus.o_out_err   = r_err;
  assign bus.o_err_cnt   = r_cnt;
endmodule

// File: tb/tb_ext_stage.sv
// tb_ext_stage: directed scenarios plus a randomized run of two ext_stage
// instances (32-bit / 8-bit counter and 64-bit / 2-bit counter) against a
// plain-arithmetic reference model.
module tb_ext_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  ext_stage_if #(.DATA_W(32), .IMM_W(16), .CNT_W(8)) bus_a ();
  ext_stage_if #(.DATA_W(64), .IMM_W(16), .CNT_W(2)) bus_b ();

  ext_stage #(.DATA_W(32), .IMM_W(16), .CNT_W(8)) u_a (
    .i_clk(clk), .i_reset(reset), .bus(bus_a.slave)
  );
  ext_stage #(.DATA_W(64), .IMM_W(16), .CNT_W(2)) u_b (
    .i_clk(clk), .i_reset(reset), .bus(bus_b.slave)
  );

  typedef struct {
    logic        v;
    logic        e;
    logic [63:0] x;
    int          c;
  } mstate_t;

  // Extension result from the mode rules: returns {misaligned, value}.
  function automatic logic [64:0] calc(input int dw, input logic [2:0] op,
                                       input logic [15:0] imm,
                                       input logic [63:0] mem, input int addr);
    logic [63:0] v;
    logic        err;
    v   = 64'h0;
    err = 1'b0;
    case (op)
      3'd0: v = {48'h0, imm};
      3'd1: begin
        v = {48'h0, imm};
        if (imm >= 16'h8000) v = v - 64'h10000;
      end
      3'd2: begin
        v = {48'h0, imm} << 16;
        if (imm >= 16'h8000) v = v - 64'h1_0000_0000;
      end
      3'd3, 3'd4: begin
        v = (mem >> (8 * addr)) & 64'hFF;
        if (op == 3'd3 && v >= 64'h80) v = v - 64'h100;
      end
      3'd5, 3'd6: begin
        err = (addr % 2) != 0;
        v = (mem >> (16 * (addr / 2))) & 64'hFFFF;
        if (op == 3'd5 && v >= 64'h8000) v = v - 64'h10000;
      end
      default: begin
        err = (addr % 4) != 0;
        v = (mem >> (32 * (addr / 4))) & 64'hFFFF_FFFF;
        if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
      end
    endcase
    if (err) v = 64'h0;
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return {err, v};
  endfunction

  // Next register state from the per-edge priority rules.
  function automatic mstate_t next_state(input mstate_t s, input int dw, input int cmax,
                                         input logic rst, input logic fl, input logic st,
                                         input logic vl, input logic [2:0] op,
                                         input logic [15:0] imm, input logic [63:0] mem,
                                         input int addr);
    mstate_t     n;
    logic [64:0] r;
    n = s;
    if (rst) begin
      n.v = 1'b0; n.e = 1'b0; n.x = 64'h0; n.c = 0;
    end else if (fl) begin
      n.v = 1'b0; n.e = 1'b0; n.x = 64'h0;
    end else if (!st) begin
      n.v = vl;
      if (vl) begin
        r   = calc(dw, op, imm, mem, addr);
        n.e = r[64];
        n.x = r[63:0];
        if (r[64] && n.c < cmax) n.c = n.c + 1;
      end else begin
        n.e = 1'b0; n.x = 64'h0;
      end
    end
    return n;
  endfunction

  task automatic drive_a(input logic vl, input logic st, input logic fl, input logic [2:0] op,
                         input logic [15:0] imm, input logic [31:0] mem, input logic [1:0] addr);
    bus_a.i_in_valid = vl; bus_a.i_stall = st; bus_a.i_flush = fl; bus_a.i_op = op;
    bus_a.i_imm = imm; bus_a.i_mem_data = mem; bus_a.i_addr_lo = addr;
  endtask

  task automatic drive_b(input logic vl, input logic st, input logic fl, input logic [2:0] op,
                         input logic [15:0] imm, input logic [63:0] mem, input logic [2:0] addr);
    bus_b.i_in_valid = vl; bus_b.i_stall = st; bus_b.i_flush = fl; bus_b.i_op = op;
    bus_b.i_imm = imm; bus_b.i_mem_data = mem; bus_b.i_addr_lo = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    drive_b(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 64'h0, 3'd0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_a(1'b1, 1'b1, 1'b1, 3'd7, 16'hFFFF, 32'hFFFF_FFFF, 2'd1);
    drive_b(1'b1, 1'b0, 1'b0, 3'd5, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    tick();
    tick();
    n_checks++;
    if ({bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt} !== 42'h0) begin
      n_fail++;
      $display("FAIL reset_a: got v=%b e=%b x=%h c=%0d, want all zero",
               bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt);
    end
    n_checks++;
    if ({bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_b: got v=%b e=%b x=%h c=%0d, want all zero",
               bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_imm_modes();
    logic [2:0]  ops [3] = '{3'd1, 3'd0, 3'd2};
    logic [15:0] imms[3] = '{16'h8001, 16'h8001, 16'h1234};
    logic [31:0] exps[3] = '{32'hFFFF8001, 32'h00008001, 32'h12340000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b0, 1'b0, ops[i], imms[i], 32'hDEAD_BEEF, 2'd3);
      tick();
      n_checks++;
      if ({bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out} !== {1'b1, 1'b0, exps[i]}) begin
        n_fail++;
        $display("FAIL imm_mode%0d: got v=%b e=%b x=%h, want v=1 e=0 x=%h",
                 i, bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, exps[i]);
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  ops [4] = '{3'd3, 3'd4, 3'd5, 3'd6};
    logic [1:0]  adrs[4] = '{2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b0, 1'b0, ops[i], 16'hFFFF, 32'h80FF7F01, adrs[i]);
      tick();
      n_checks++;
      if ({bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out} !== {1'b1, 1'b0, exps[i]}) begin
        n_fail++;
        $display("FAIL load%0d: got v=%b e=%b x=%h, want v=1 e=0 x=%h",
                 i, bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, exps[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  ops [3] = '{3'd5, 3'd7, 3'd7};
    logic [1:0]  adrs[3] = '{2'd1, 2'd2, 2'd0};
    logic [31:0] exps[3] = '{32'h0, 32'h0, 32'h80FF7F01};
    logic        errs[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  cnts[3] = '{8'd1, 8'd2, 8'd2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b0, 1'b0, ops[i], 16'h0, 32'h80FF7F01, adrs[i]);
      tick();
      n_checks++;
      if ({bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt} !== {errs[i], exps[i], cnts[i]}) begin
        n_fail++;
        $display("FAIL misalign%0d: got e=%b x=%h c=%0d, want e=%b x=%h c=%0d", i,
                 bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt, errs[i], exps[i], cnts[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive_a(1'b1, 1'b0, 1'b0, 3'd1, 16'hFFFF, 32'h0, 2'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt} !==
          {1'b1, 1'b0, 32'hFFFF_FFFF, 8'd0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b e=%b x=%h c=%0d, want v=1 e=0 x=ffffffff c=0",
                 i, bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt);
      end
      if (i < 3) begin
        drive_a(1'b1, 1'b1, 1'b0, 3'(3'd5 + 3'(i)), 16'(i), $urandom, 2'(2 * i + 1));
        tick();
      end
    end
    drive_a(1'b1, 1'b1, 1'b1, 3'd1, 16'h1234, 32'h0, 2'd0);
    tick();
    n_checks++;
    if ({bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_over_stall: got v=%b e=%b x=%h, want all zero",
               bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive_a(1'b1, 1'b0, 1'b0, 3'd0, 16'h00AB, 32'h0, 2'd0);
    tick();
    n_checks++;
    if (bus_a.o_ext_out !== 32'h000000AB) begin
      n_fail++;
      $display("FAIL pre_stall_load: got x=%h, want 000000ab", bus_a.o_ext_out);
    end
    reset = 1'b1;
    drive_a(1'b1, 1'b1, 1'b0, 3'd0, 16'h5555, 32'h0, 2'd0);
    tick();
    n_checks++;
    if ({bus_a.o_out_valid, bus_a.o_ext_out} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_in_stall: got v=%b x=%h, want v=0 x=0", bus_a.o_out_valid, bus_a.o_ext_out);
    end
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 1'b0, 3'd0, 16'h1234, 32'h0, 2'd0);
    tick();
    n_checks++;
    if ({bus_a.o_out_valid, bus_a.o_ext_out} !== {1'b1, 32'h00001234}) begin
      n_fail++;
      $display("FAIL first_after_reset: got v=%b x=%h, want v=1 x=00001234",
               bus_a.o_out_valid, bus_a.o_ext_out);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] cnts[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_b(1'b1, 1'b0, 1'b0, 3'd5, 16'h0, $urandom, 3'(2 * i + 1));
      tick();
      n_checks++;
      if ({bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt} !==
          {1'b1, 1'b1, 64'h0, cnts[i]}) begin
        n_fail++;
        $display("FAIL saturate%0d: got v=%b e=%b x=%h c=%0d, want v=1 e=1 x=0 c=%0d", i,
                 bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt, cnts[i]);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt} !== 68'h0) begin
      n_fail++;
      $display("FAIL saturate_reset: got v=%b e=%b x=%h c=%0d, want all zero",
               bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt);
    end
  endtask

  task automatic test_wide();
    drive_b(1'b1, 1'b0, 1'b0, 3'd7, 16'h0, 64'h80000000_00000001, 3'd4);
    tick();
    n_checks++;
    if ({bus_b.o_out_err, bus_b.o_ext_out} !== {1'b0, 64'hFFFFFFFF80000000}) begin
      n_fail++;
      $display("FAIL wide_lw: got e=%b x=%h, want e=0 x=ffffffff80000000",
               bus_b.o_out_err, bus_b.o_ext_out);
    end
    drive_b(1'b1, 1'b0, 1'b0, 3'd2, 16'h8000, 64'h0, 3'd0);
    tick();
    n_checks++;
    if ({bus_b.o_out_err, bus_b.o_ext_out} !== {1'b0, 64'hFFFFFFFF80000000}) begin
      n_fail++;
      $display("FAIL wide_lui: got e=%b x=%h, want e=0 x=ffffffff80000000",
               bus_b.o_out_err, bus_b.o_ext_out);
    end
  endtask

  task automatic test_random();
    mstate_t     ma;
    mstate_t     mb;
    logic        rst, fa, sa, va, fb, sb, vb;
    logic [2:0]  opa, opb;
    logic [15:0] ima, imb;
    logic [31:0] mema;
    logic [63:0] memb;
    int          ada, adb;
    do_reset();
    ma = '{v: 1'b0, e: 1'b0, x: 64'h0, c: 0};
    mb = '{v: 1'b0, e: 1'b0, x: 64'h0, c: 0};
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 31) == 0);
      fa   = ($urandom_range(0, 7) == 0);
      sa   = ($urandom_range(0, 3) == 0);
      va   = ($urandom_range(0, 3) != 0);
      fb   = ($urandom_range(0, 7) == 0);
      sb   = ($urandom_range(0, 3) == 0);
      vb   = ($urandom_range(0, 3) != 0);
      opa  = 3'($urandom_range(0, 7));
      opb  = 3'($urandom_range(0, 7));
      ima  = 16'($urandom);
      imb  = 16'($urandom);
      mema = $urandom;
      memb = {$urandom, $urandom};
      ada  = $urandom_range(0, 3);
      adb  = $urandom_range(0, 7);
      reset = rst;
      drive_a(va, sa, fa, opa, ima, mema, 2'(ada));
      drive_b(vb, sb, fb, opb, imb, memb, 3'(adb));
      ma = next_state(ma, 32, 255, rst, fa, sa, va, opa, ima, {32'h0, mema}, ada);
      mb = next_state(mb, 64, 3, rst, fb, sb, vb, opb, imb, memb, adb);
      tick();
      n_checks++;
      if ({bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt} !==
          {ma.v, ma.e, ma.x[31:0], 8'(ma.c)}) begin
        n_fail++;
        $display("FAIL random_a@%0d: got v=%b e=%b x=%h c=%0d, want v=%b e=%b x=%h c=%0d", i,
                 bus_a.o_out_valid, bus_a.o_out_err, bus_a.o_ext_out, bus_a.o_err_cnt,
                 ma.v, ma.e, ma.x[31:0], ma.c);
      end
      n_checks++;
      if ({bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt} !==
          {mb.v, mb.e, mb.x, 2'(mb.c)}) begin
        n_fail++;
        $display("FAIL random_b@%0d: got v=%b e=%b x=%h c=%0d, want v=%b e=%b x=%h c=%0d", i,
                 bus_b.o_out_valid, bus_b.o_out_err, bus_b.o_ext_out, bus_b.o_err_cnt,
                 mb.v, mb.e, mb.x, mb.c);
      end
    end
    reset = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_imm_modes();
    test_loads();
    test_misalign();
    test_stall_flush();
    test_reset_mid_stall();
    test_saturate();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time bound so a broken run still terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/ext_stage.md
EXT_STAGE -- requirements
Module: ext_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath/result width; SHALL be a power of two, >= 32 and >= IMM_W+16.
REQ-002 Parameter IMM_W, default 16, immediate field width.
REQ-003 Parameter CNT_W, default 8, width of the alignment-error counter.
REQ-004 Derived AW = log2(DATA_W/8), width of the byte-offset input.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  request present this cycle.
REQ-008 stall  input  1  hold the output register.
REQ-009 flush  input  1  discard the output register contents.
REQ-010 op  input  3  mode: 0 ZERO, 1 SIGN, 2 LUI, 3 LB, 4 LBU, 5 LH, 6 LHU, 7 LW.
REQ-011 imm  input  IMM_W  immediate for modes 0-2.
REQ-012 mem_data  input  DATA_W  memory read word for modes 3-7.
REQ-013 addr_lo  input  AW  byte offset of the access within mem_data.
REQ-014 out_valid  output  1  ext_out holds a valid result.
REQ-015 ext_out  output  DATA_W  registered extension result.
REQ-016 out_err  output  1  registered misalignment flag for the result in ext_out.
REQ-017 err_cnt  output  CNT_W  saturating count of misaligned requests accepted.

Function
REQ-018 ZERO: ext_out = imm zero-extended to DATA_W.
REQ-019 SIGN: ext_out = imm sign-extended from bit IMM_W-1.
REQ-020 LUI: bits [15:0] = 0, bits [IMM_W+15:16] = imm, upper bits = copies of imm[IMM_W-1].
REQ-021 LB/LBU: byte addr_lo of mem_data (little-endian, byte 0 = bits [7:0]), sign-/zero-extended.
REQ-022 LH/LHU: halfword addr_lo[AW-1:1] of mem_data, sign-/zero-extended; misaligned when addr_lo[0]=1.
REQ-023 LW: 32-bit word addr_lo[AW-1:2] of mem_data, sign-extended to DATA_W; misaligned when addr_lo[1:0]!=0.
REQ-024 Modes 0-4 are never misaligned; addr_lo and mem_data are ignored for modes 0-2.
REQ-025 Misaligned request: ext_out SHALL be all zeros; out_err=1.
REQ-026 Latency exactly 1 cycle: request sampled at edge N appears on outputs after edge N.
REQ-027 Per-edge priority: reset > flush > stall > load.
REQ-028 flush=1: out_valid<=0, out_err<=0, ext_out<=0, regardless of stall or in_valid.
REQ-029 stall=1 (no flush): out_valid, ext_out, out_err hold; input request not captured; err_cnt unchanged.
REQ-030 Load (no flush, no stall): out_valid<=in_valid; when in_valid=1, ext_out and out_err take the computed result; when in_valid=0, ext_out<=0 and out_err<=0.
REQ-031 err_cnt increments by 1 on each load edge with in_valid=1 and misaligned request; saturates at 2^CNT_W-1, no wrap.
REQ-032 Flush does not alter err_cnt; only reset clears it.
REQ-033 Outputs depend only on registers; no combinational path from inputs to outputs.

Reset
REQ-034 reset=1 at an edge: out_valid=0, ext_out=0, out_err=0, err_cnt=0, overriding flush, stall, in_valid.
REQ-035 Reset asserted mid-stall SHALL discard the held result; first request after reset deasserts loads normally on the next edge.

Verification
REQ-036 SIGN imm=16'h8001, then ZERO imm=16'h8001, then LUI imm=16'h1234 -> ext_out 32'hFFFF8001, 32'h00008001, 32'h12340000 on consecutive cycles, out_valid=1.
REQ-037 mem_data=32'h80FF7F01: LB addr_lo=3 -> 32'hFFFFFF80; LBU addr_lo=2 -> 32'h000000FF; LH addr_lo=2 -> 32'hFFFF80FF; LHU addr_lo=0 -> 32'h00007F01.
REQ-038 LH addr_lo=1 then LW addr_lo=2 -> ext_out=0, out_err=1 each cycle, err_cnt 0->1->2; LW addr_lo=0 next -> out_err=0, err_cnt stays 2.
REQ-039 Load SIGN imm=16'hFFFF, then stall=1 for 3 cycles with changing inputs -> ext_out stays 32'hFFFFFFFF, out_valid=1; flush=1 and stall=1 together -> out_valid=0, ext_out=0.
REQ-040 CNT_W=2, five misaligned LH requests -> err_cnt 1,2,3,3,3; reset -> err_cnt=0 and all outputs 0 on the same edge.
REQ-041 DATA_W=64, LW addr_lo=4, mem_data=64'h80000000_00000001 -> ext_out=64'hFFFFFFFF80000000; LUI imm=16'h8000 -> 64'hFFFFFFFF80000000.
